// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vm_pkg
// Brief   : Shared types and defaults for the vector-machine feeder path.
// Revision: 1.0 - initial release
// ============================================================================
package vm_pkg;

    localparam int VM_WIDTH = 24;
    localparam int VM_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } vm_state_t;

endpackage : vm_pkg
`default_nettype wire

// File: rtl/vector_buffer.sv
`default_nettype none
// ============================================================================
// Module  : vector_buffer
// Brief   : DEPTH x WIDTH element store, one synchronous write port and one
//           asynchronous read port.
// Revision: 1.0 - initial release
// ============================================================================
module vector_buffer
    import vm_pkg::*;
#(
    parameter  int WIDTH = VM_WIDTH,
    parameter  int DEPTH = VM_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store one element per accepted write; contents never need clearing.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : vector_buffer
`default_nettype wire

// File: rtl/vector_feeder.sv
`default_nettype none
// ============================================================================
// Module  : vector_feeder
// Brief   : Buffers up to DEPTH elements, then streams them one per clock as
//           {data_out, load} into the accumulator, with pause and done pulse.
// Revision: 1.0 - initial release
// ============================================================================
module vector_feeder
    import vm_pkg::*;
#(
    parameter  int WIDTH = VM_WIDTH,
    parameter  int DEPTH = VM_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] data_out,
    output logic             load,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    level,
    output logic             full
);

    vm_state_t        r_state, w_state;
    logic [CW-1:0]    r_wp, w_wp;
    logic [CW-1:0]    r_rp, w_rp;
    logic [CW-1:0]    r_level, w_level;
    logic [WIDTH-1:0] r_data, w_data;
    logic             r_load, w_load;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             r_full, w_full;
    logic             w_we;
    logic [WIDTH-1:0] w_rdata;

    vector_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wp[AW-1:0]),
        .i_wdata (wr_data),
        .i_raddr (r_rp[AW-1:0]),
        .o_rdata (w_rdata)
    );

    // State and output registers; reset discards any vector in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_data  <= '0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_wp    <= w_wp;
            r_rp    <= w_rp;
            r_level <= w_level;
            r_data  <= w_data;
            r_load  <= w_load;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_full  <= w_full;
        end
    end

    // Next-state and next-output logic; load and done are single-cycle strobes.
    always_comb begin
        w_state = r_state;
        w_wp    = r_wp;
        w_rp    = r_rp;
        w_level = r_level;
        w_data  = r_data;
        w_load  = 1'b0;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_we    = 1'b0;

        case (r_state)
            IDLE: begin
                // A write in the same cycle as start lands first and is streamed.
                if (wr_en && !r_full) begin
                    w_we    = 1'b1;
                    w_wp    = r_wp + CW'(1);
                    w_level = r_level + CW'(1);
                end
                if (start) begin
                    w_rp    = '0;
                    w_busy  = 1'b1;
                    w_state = (w_level != '0) ? STREAM : FINISH;
                end
            end
            STREAM: begin
                if (!pause) begin
                    w_data = w_rdata;
                    w_load = 1'b1;
                    w_rp   = r_rp + CW'(1);
                    if (r_rp + CW'(1) == r_level) begin
                        w_state = FINISH;
                    end
                end
            end
            FINISH: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_wp    = '0;
                w_rp    = '0;
                w_level = '0;
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        w_full = (w_level == CW'(DEPTH));
    end

    assign data_out = r_data;
    assign load     = r_load;
    assign busy     = r_busy;
    assign done     = r_done;
    assign level    = r_level;
    assign full     = r_full;

endmodule : vector_feeder
`default_nettype wire

// File: tb/tb_vector_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_vector_feeder
// Brief   : Self-checking bench for vector_feeder against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vector_feeder;

    localparam int WIDTH = 24;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int NCYC  = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             load;
    logic             busy;
    logic             done;
    logic [CW-1:0]    level;
    logic             full;

    int checks = 0;
    int errors = 0;

    // Elements the model believes are buffered, in write order.
    logic [WIDTH-1:0] model_q [$];

    vector_feeder #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .start    (start),
        .pause    (pause),
        .data_out (data_out),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .level    (level),
        .full     (full)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus; the model accepts writes while there is room.
    task automatic drive(input logic we, input logic [WIDTH-1:0] d, input logic st);
        @(negedge clk);
        wr_en   = we;
        wr_data = d;
        start   = st;
        pause   = 1'b0;
        if (we && model_q.size() < DEPTH) model_q.push_back(d);
    endtask

    // Record the stream following a start. Cycle n samples the edge n after
    // the start edge and sets pause for the following edge from pm[n].
    task automatic collect(input logic [63:0] pm, input bit inject,
                           output logic [WIDTH-1:0] got [$], output logic [63:0] lb,
                           output int dat, output int dcnt);
        got  = {};
        lb   = '0;
        dat  = -1;
        dcnt = 0;
        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            if (load) got.push_back(data_out);
            lb[n] = load;
            if (done) begin
                dcnt++;
                if (dat < 0) dat = n;
            end
            if (inject && busy) begin
                wr_en   = 1'($urandom_range(0, 1));
                wr_data = WIDTH'($urandom);
                start   = 1'($urandom_range(0, 1));
            end else begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            pause = pm[n];
        end
        wr_en = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    // Abstract timing: an element goes out on every un-paused opportunity
    // until all are issued; done appears the cycle after the last one.
    function automatic void model_timing(input int n_el, input logic [63:0] pm,
                                         output logic [63:0] lb, output int dat);
        int issued = 0;
        lb  = '0;
        dat = 1;
        for (int m = 0; m < NCYC - 1 && issued < n_el; m++) begin
            if (!pm[m]) begin
                lb[m + 1] = 1'b1;
                issued++;
                dat = m + 2;
            end
        end
    endfunction

    task automatic test_reset;
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load got=%b exp=0", load); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_out); end
    endtask

    task automatic test_basic;
        logic [WIDTH-1:0] got [$];
        logic [WIDTH-1:0] exp [$];
        logic [63:0] lb, elb;
        int dat, edat, dcnt;
        logic [WIDTH-1:0] s_got, s_exp;
        drive(1'b1, 24'hC01401, 1'b0);
        drive(1'b1, 24'hD01402, 1'b0);
        drive(1'b1, 24'hC01400, 1'b0);
        drive(1'b0, '0, 1'b0);
        checks++; if (level !== CW'(3)) begin errors++; $display("FAIL basic_level got=%0d exp=3", level); end
        drive(1'b0, '0, 1'b1);
        exp = model_q; model_q = {};
        collect('0, 1'b0, got, lb, dat, dcnt);
        model_timing(exp.size(), '0, elb, edat);
        checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL basic_elem%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
        checks++; if (lb !== elb) begin errors++; $display("FAIL basic_loads got=%h exp=%h", lb, elb); end
        checks++; if (dat !== edat || dcnt !== 1) begin errors++; $display("FAIL basic_done got=%0d/%0d exp=%0d/1", dat, dcnt, edat); end
        s_got = '0; s_exp = '0;
        foreach (got[i]) s_got = s_got + got[i];
        foreach (exp[i]) s_exp = s_exp + exp[i];
        checks++; if (s_got !== s_exp) begin errors++; $display("FAIL basic_sum got=%h exp=%h", s_got, s_exp); end
        checks++; if (level !== '0 || busy !== 1'b0) begin errors++; $display("FAIL basic_after got=%0d/%b exp=0/0", level, busy); end
    endtask

    task automatic test_full;
        logic [WIDTH-1:0] got [$];
        logic [WIDTH-1:0] exp [$];
        logic [63:0] lb, elb;
        int dat, edat, dcnt;
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, WIDTH'($urandom), 1'b0);
        drive(1'b0, '0, 1'b0);
        checks++; if (level !== CW'(DEPTH) || full !== 1'b1) begin errors++; $display("FAIL full_flag got=%0d/%b exp=%0d/1", level, full, DEPTH); end
        drive(1'b0, '0, 1'b1);
        exp = model_q; model_q = {};
        collect('0, 1'b0, got, lb, dat, dcnt);
        model_timing(exp.size(), '0, elb, edat);
        checks++; if (got.size() !== DEPTH) begin errors++; $display("FAIL full_count got=%0d exp=%0d", got.size(), DEPTH); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL full_elem%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
        checks++; if (lb !== elb || dat !== edat) begin errors++; $display("FAIL full_timing got=%h/%0d exp=%h/%0d", lb, dat, elb, edat); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_after got=%b exp=0", full); end
    endtask

    task automatic test_empty_start;
        logic [WIDTH-1:0] got [$];
        logic [63:0] lb;
        int dat, dcnt;
        drive(1'b0, '0, 1'b1);
        collect('0, 1'b0, got, lb, dat, dcnt);
        checks++; if (lb !== 64'd0) begin errors++; $display("FAIL empty_loads got=%h exp=0", lb); end
        checks++; if (dat !== 1 || dcnt !== 1) begin errors++; $display("FAIL empty_done got=%0d/%0d exp=1/1", dat, dcnt); end
    endtask

    task automatic test_pause;
        logic [WIDTH-1:0] got [$];
        logic [WIDTH-1:0] exp [$];
        logic [63:0] lb, elb, pm;
        int dat, edat, dcnt;
        for (int i = 0; i < 3; i++) drive(1'b1, WIDTH'($urandom), 1'b0);
        drive(1'b0, '0, 1'b1);
        exp = model_q; model_q = {};
        pm = 64'h6;
        collect(pm, 1'b0, got, lb, dat, dcnt);
        model_timing(exp.size(), pm, elb, edat);
        checks++; if (lb[7:0] !== 8'b0011_0010) begin errors++; $display("FAIL pause_pattern got=%b exp=00110010", lb[7:0]); end
        checks++; if (lb !== elb || dat !== edat) begin errors++; $display("FAIL pause_timing got=%h/%0d exp=%h/%0d", lb, dat, elb, edat); end
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL pause_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL pause_elem%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_ignore_busy;
        logic [WIDTH-1:0] got [$];
        logic [WIDTH-1:0] exp [$];
        logic [63:0] lb, elb;
        int dat, edat, dcnt;
        for (int i = 0; i < 4; i++) drive(1'b1, WIDTH'($urandom), 1'b0);
        drive(1'b0, '0, 1'b1);
        exp = model_q; model_q = {};
        collect('0, 1'b1, got, lb, dat, dcnt);
        model_timing(exp.size(), '0, elb, edat);
        checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL busy_count got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL busy_elem%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
        checks++; if (lb !== elb || dcnt !== 1) begin errors++; $display("FAIL busy_timing got=%h/%0d exp=%h/1", lb, dcnt, elb); end
        checks++; if (level !== '0) begin errors++; $display("FAIL busy_level got=%0d exp=0", level); end
    endtask

    task automatic test_write_with_start;
        logic [WIDTH-1:0] got [$];
        logic [WIDTH-1:0] exp [$];
        logic [63:0] lb;
        int dat, dcnt;
        drive(1'b1, WIDTH'($urandom), 1'b0);
        drive(1'b1, WIDTH'($urandom), 1'b0);
        drive(1'b1, WIDTH'($urandom), 1'b1);
        exp = model_q; model_q = {};
        collect('0, 1'b0, got, lb, dat, dcnt);
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL wrstart_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL wrstart_elem%0d got=%h exp=%h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        drive(1'b1, WIDTH'($urandom), 1'b0);
        drive(1'b1, WIDTH'($urandom), 1'b0);
        drive(1'b0, '0, 1'b1);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_q = {};
        #1;
        checks++; if ({load, done, busy, full} !== 4'b0 || level !== '0 || data_out !== '0) begin
            errors++; $display("FAIL midreset_outs got=%b%b%b%b lvl=%0d d=%h exp=all0", load, done, busy, full, level, data_out);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || load || busy || level != '0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_quiet got=%0d exp=0", seen); end
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] got [$];
        logic [WIDTH-1:0] exp [$];
        logic [63:0] lb, elb, pm;
        int dat, edat, dcnt, nw, bad;
        for (int it = 0; it < 20; it++) begin
            nw = $urandom_range(0, DEPTH + 2);
            for (int i = 0; i < nw; i++) drive(1'b1, WIDTH'($urandom), 1'b0);
            drive(1'b0, '0, 1'b0);
            checks++; if (level !== CW'(model_q.size()) || full !== (model_q.size() == DEPTH)) begin
                errors++; $display("FAIL rand%0d_level got=%0d/%b exp=%0d", it, level, full, model_q.size());
            end
            drive(1'b0, '0, 1'b1);
            exp = model_q; model_q = {};
            pm = '0;
            for (int b = 0; b < 64; b++) pm[b] = ($urandom_range(0, 3) == 0);
            collect(pm, 1'b1, got, lb, dat, dcnt);
            model_timing(exp.size(), pm, elb, edat);
            bad = (got.size() != exp.size()) ? 1 : 0;
            for (int i = 0; i < exp.size() && i < got.size(); i++) if (got[i] !== exp[i]) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL rand%0d_data got=%0d bad exp=0 (n=%0d/%0d)", it, bad, got.size(), exp.size()); end
            checks++; if (lb !== elb || dat !== edat || dcnt !== 1) begin
                errors++; $display("FAIL rand%0d_timing got=%h/%0d/%0d exp=%h/%0d/1", it, lb, dat, dcnt, elb, edat);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        reset = 1'b1;
        @(negedge clk);
        test_basic;
        test_full;
        test_empty_start;
        test_pause;
        test_ignore_busy;
        test_write_with_start;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vector_feeder
`default_nettype wire
